// File: rtl/tx_order_framer_pkg.sv
// Shared field widths, beat bit positions and frame states for tx_order_framer.
// Beat layout is fixed at 64 bits: W0 = {qty, price, inst_id}, W1 = {seq, ch, pad, latency, side}.
package tx_order_framer_pkg;

  localparam int INST_ID_W = 16;
  localparam int PRICE_W   = 32;
  localparam int SIZE_W    = 16;
  localparam int TS_W      = 48;
  localparam int BEAT_W    = 64;

  localparam int W0_INST_LSB  = 0;
  localparam int W0_PRICE_LSB = W0_INST_LSB + INST_ID_W;
  localparam int W0_QTY_LSB   = W0_PRICE_LSB + PRICE_W;

  // W1 header {seq, ch, pad} always fills the 15 bits above latency and side.
  localparam int W1_SIDE_BIT = 0;
  localparam int W1_LAT_LSB  = 1;
  localparam int W1_HDR_W    = BEAT_W - TS_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_W0   = 2'd1,
    ST_W1   = 2'd2,
    ST_CK   = 2'd3
  } frame_state_e;

  function automatic logic [BEAT_W-1:0] pack_w0(input logic [SIZE_W-1:0]    qty,
                                                input logic [PRICE_W-1:0]   price,
                                                input logic [INST_ID_W-1:0] inst_id);
    pack_w0 = '0;
    pack_w0[W0_QTY_LSB +: SIZE_W]      = qty;
    pack_w0[W0_PRICE_LSB +: PRICE_W]   = price;
    pack_w0[W0_INST_LSB +: INST_ID_W]  = inst_id;
  endfunction

endpackage

// File: rtl/tx_order_framer_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr.
// rr_ptr moves to one past the granted channel only when the grant is consumed.
module tx_order_framer_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid
);

  logic [IDX_W-1:0] rr_ptr;
  int               cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_CH;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance && grant_valid) begin
      if (int'(grant_idx) == NUM_CH - 1) rr_ptr <= '0;
      else                               rr_ptr <= grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/tx_order_framer.sv
// Multi-channel order framer: round-robin accept, then W0/W1 beats on a valid/ready stream.
// Define TX_ORDER_CKSUM_EN to append a CK = W0 ^ W1 beat carrying tx_last.
module tx_order_framer
  import tx_order_framer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int SEQ_W  = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           in_valid,
  output logic [NUM_CH-1:0]           in_ready,
  input  logic [NUM_CH*INST_ID_W-1:0] in_inst_id,
  input  logic [NUM_CH*PRICE_W-1:0]   in_price,
  input  logic [NUM_CH*SIZE_W-1:0]    in_qty,
  input  logic [NUM_CH-1:0]           in_side,
  input  logic [NUM_CH*TS_W-1:0]      in_ts,
  input  logic [TS_W-1:0]             ts_now,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [BEAT_W-1:0]           tx_data,
  output logic                        tx_last,
  output logic [CH_W-1:0]             tx_ch,
  output logic [31:0]                 frame_cnt
);

  frame_state_e state_q, state_d;

  logic [NUM_CH-1:0]    grant;
  logic [CH_W-1:0]      grant_idx;
  logic                 grant_valid;
  logic                 accept;
  logic                 last_hs;

  logic [INST_ID_W-1:0] sel_inst;
  logic [PRICE_W-1:0]   sel_price;
  logic [SIZE_W-1:0]    sel_qty;
  logic                 sel_side;
  logic [TS_W-1:0]      sel_ts;
  logic [TS_W-1:0]      latency;

  logic [SEQ_W-1:0]     seq_q;
  logic [BEAT_W-1:0]    w0_q, w1_q, w0_next, w1_next;

  tx_order_framer_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CH_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (in_valid),
    .advance     (accept),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Both beats are built at accept time so the input channel is free immediately.
  always_comb begin
    sel_inst  = in_inst_id[int'(grant_idx)*INST_ID_W +: INST_ID_W];
    sel_price = in_price[int'(grant_idx)*PRICE_W +: PRICE_W];
    sel_qty   = in_qty[int'(grant_idx)*SIZE_W +: SIZE_W];
    sel_side  = in_side[grant_idx];
    sel_ts    = in_ts[int'(grant_idx)*TS_W +: TS_W];
    latency   = ts_now - sel_ts;

    w0_next = pack_w0(sel_qty, sel_price, sel_inst);

    w1_next = '0;
    w1_next[W1_SIDE_BIT]                   = sel_side;
    w1_next[W1_LAT_LSB +: TS_W]            = latency;
    w1_next[BEAT_W-1 -: (SEQ_W + CH_W)]    = {seq_q, grant_idx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    in_ready = '0;
    tx_valid = (state_q != ST_IDLE);
    tx_data  = '0;
    tx_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = grant;
        if (grant_valid) begin
          accept  = 1'b1;
          state_d = ST_W0;
        end
      end
      ST_W0: begin
        tx_data = w0_q;
        if (tx_ready) state_d = ST_W1;
      end
      ST_W1: begin
        tx_data = w1_q;
`ifdef TX_ORDER_CKSUM_EN
        if (tx_ready) state_d = ST_CK;
`else
        tx_last = 1'b1;
        if (tx_ready) state_d = ST_IDLE;
`endif
      end
      ST_CK: begin
        tx_data = w0_q ^ w1_q;
        tx_last = 1'b1;
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign last_hs = tx_valid & tx_ready & tx_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0_q      <= '0;
      w1_q      <= '0;
      tx_ch     <= '0;
      seq_q     <= '0;
      frame_cnt <= '0;
    end else begin
      if (accept) begin
        w0_q  <= w0_next;
        w1_q  <= w1_next;
        tx_ch <= grant_idx;
        seq_q <= seq_q + SEQ_W'(1);
      end
      if (last_hs) frame_cnt <= frame_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_tx_order_framer.sv
// Scoreboard bench for tx_order_framer (SEQ_W=4 so sequence wrap is reachable).
// Honours TX_ORDER_CKSUM_EN to expect the extra checksum beat.
module tb_tx_order_framer;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int SEQ_W  = 4;
`ifdef TX_ORDER_CKSUM_EN
  localparam int BEATS = 3;
`else
  localparam int BEATS = 2;
`endif

  typedef struct packed {
    logic [63:0]     data;
    logic            last;
    logic [CH_W-1:0] ch;
  } beat_t;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_CH-1:0]    in_valid;
  logic [NUM_CH-1:0]    in_ready;
  logic [NUM_CH*16-1:0] in_inst_id;
  logic [NUM_CH*32-1:0] in_price;
  logic [NUM_CH*16-1:0] in_qty;
  logic [NUM_CH-1:0]    in_side;
  logic [NUM_CH*48-1:0] in_ts;
  logic [47:0]          ts_now;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [63:0]          tx_data;
  logic                 tx_last;
  logic [CH_W-1:0]      tx_ch;
  logic [31:0]          frame_cnt;

  beat_t       exp_q[$];
  int          checks;
  int          errors;
  int          cyc;
  int          accept_cyc;
  int          frames_exp;
  logic [SEQ_W-1:0] seq_model;
  logic [63:0] last_w0;
  logic [63:0] last_w1;

  tx_order_framer #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .SEQ_W  (SEQ_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst_id (in_inst_id),
    .in_price   (in_price),
    .in_qty     (in_qty),
    .in_side    (in_side),
    .in_ts      (in_ts),
    .ts_now     (ts_now),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .tx_ch      (tx_ch),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Every beat handshake is compared against the oldest expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && tx_valid && tx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL beat_unexpected data=%h last=%0b ch=%0d, required no beat", tx_data, tx_last, tx_ch);
      end else begin
        e = exp_q.pop_front();
        if ({tx_data, tx_last, tx_ch} !== {e.data, e.last, e.ch}) begin
          errors++;
          $display("[TB] FAIL beat data=%h last=%0b ch=%0d, required data=%h last=%0b ch=%0d",
                   tx_data, tx_last, tx_ch, e.data, e.last, e.ch);
        end
      end
    end
  end

  task automatic load_ch(input int ch, input logic [15:0] inst, input logic [31:0] price,
                         input logic [15:0] qty, input logic side, input logic [47:0] ts_in);
    in_inst_id[ch*16 +: 16] = inst;
    in_price[ch*32 +: 32]   = price;
    in_qty[ch*16 +: 16]     = qty;
    in_side[ch]             = side;
    in_ts[ch*48 +: 48]      = ts_in;
    in_valid[ch]            = 1'b1;
  endtask

  // Waits for the grant, checks it is channel ch, queues the frame, returns at T+1 (+1 time unit).
  task automatic expect_accept(input int ch);
    bit          got;
    logic [3:0]  exp_rdy;
    logic [47:0] lat;
    beat_t       b;
    got     = 1'b0;
    exp_rdy = 4'b0001 << ch;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (in_ready != '0) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL accept_timeout ch=%0d in_ready=%b, required %b within 40 cycles", ch, in_ready, exp_rdy);
      return;
    end
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("[TB] FAIL grant in_ready=%b, required %b", in_ready, exp_rdy);
    end
    accept_cyc = cyc;
    lat     = ts_now - in_ts[ch*48 +: 48];
    last_w0 = {in_qty[ch*16 +: 16], in_price[ch*32 +: 32], in_inst_id[ch*16 +: 16]};
    last_w1 = {seq_model, 2'(ch), 9'b0, lat, in_side[ch]};
    b.ch = 2'(ch);
    b.data = last_w0; b.last = 1'b0; exp_q.push_back(b);
`ifdef TX_ORDER_CKSUM_EN
    b.data = last_w1; b.last = 1'b0; exp_q.push_back(b);
    b.data = last_w0 ^ last_w1; b.last = 1'b1; exp_q.push_back(b);
`else
    b.data = last_w1; b.last = 1'b1; exp_q.push_back(b);
`endif
    seq_model++;
    frames_exp++;
    @(posedge clk);
    #1;
    in_valid[ch] = 1'b0;
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int n = 0; n < 80 && !empty; n++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) empty = 1'b1;
    end
    checks++;
    if (!empty) begin
      errors++;
      $display("[TB] FAIL drain_timeout pending=%0d, required 0", exp_q.size());
    end
    checks++;
    if (frame_cnt !== 32'(frames_exp)) begin
      errors++;
      $display("[TB] FAIL frame_cnt got %0d, required %0d", frame_cnt, frames_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_ready = 1'b0; in_valid = '0; ts_now = '0;
    in_inst_id = '0; in_price = '0; in_qty = '0; in_side = '0; in_ts = '0;
    #12;
    checks++;
    if ({tx_valid, tx_last, tx_data, tx_ch, frame_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs valid=%0b last=%0b data=%h ch=%0d cnt=%0d, required all 0",
               tx_valid, tx_last, tx_data, tx_ch, frame_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tx_valid !== 1'b0 || in_ready !== '0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset valid=%0b in_ready=%b, required 0 and 0000", tx_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    tx_ready = 1'b1;
    ts_now   = 48'd1010;
    load_ch(0, 16'h0042, 32'h0001_86A0, 16'd100, 1'b1, 48'd1000);
    expect_accept(0);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 64'h0064_0001_86A0_0042 || tx_ch !== 2'd0) begin
      errors++;
      $display("[TB] FAIL basic_w0 valid=%0b data=%h ch=%0d, required 1 0064000186a00042 0", tx_valid, tx_data, tx_ch);
    end
    @(posedge clk); #1;
    checks++;
    if (tx_data !== {4'd0, 2'd0, 9'd0, 48'd10, 1'b1} || tx_last !== (BEATS == 2)) begin
      errors++;
      $display("[TB] FAIL basic_w1 data=%h last=%0b, required %h last=%0b",
               tx_data, tx_last, {4'd0, 2'd0, 9'd0, 48'd10, 1'b1}, (BEATS == 2));
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [63:0] w0_hold;
    logic [63:0] w1_hold;
    tx_ready = 1'b0;
    ts_now   = 48'd5000;
    load_ch(2, 16'h1234, 32'hDEAD_BEEF, 16'd7, 1'b0, 48'd4990);
    expect_accept(2);
    w0_hold = last_w0;
    w1_hold = last_w1;
    load_ch(3, 16'h5555, 32'h0000_1111, 16'd3, 1'b1, 48'd4000);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== w0_hold || tx_last !== 1'b0 || in_ready !== '0) begin
        errors++;
        $display("[TB] FAIL stall_hold cyc%0d valid=%0b data=%h last=%0b in_ready=%b, required 1 %h 0 0000",
                 i, tx_valid, tx_data, tx_last, in_ready, w0_hold);
      end
      @(posedge clk); #1;
    end
    in_valid[3] = 1'b0;
    tx_ready    = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== w1_hold) begin
      errors++;
      $display("[TB] FAIL w1_after_release valid=%0b data=%h, required 1 %h", tx_valid, tx_data, w1_hold);
    end
    drain();
  endtask

  task automatic test_round_robin();
    tx_ready = 1'b1;
    ts_now   = 48'd200;
    load_ch(3, 16'h0300, 32'd30, 16'd3, 1'b0, 48'd190);
    expect_accept(3);
    load_ch(1, 16'h0101, 32'd11, 16'd1, 1'b1, 48'd150);
    load_ch(3, 16'h0303, 32'd33, 16'd3, 1'b0, 48'd120);
    expect_accept(1);
    expect_accept(3);
    load_ch(0, 16'h0A00, 32'd1000, 16'd10, 1'b1, 48'd100);
    load_ch(1, 16'h0B01, 32'd2000, 16'd20, 1'b0, 48'd50);
    expect_accept(0);
    expect_accept(1);
    drain();
  endtask

  task automatic test_latency_wrap();
    tx_ready = 1'b1;
    ts_now   = 48'd3;
    load_ch(2, 16'h00FF, 32'd77, 16'd9, 1'b1, 48'hFFFF_FFFF_FFFE);
    expect_accept(2);
    @(posedge clk); #1;
    checks++;
    if (tx_data[48:1] !== 48'd5) begin
      errors++;
      $display("[TB] FAIL latency_wrap got %0d, required 5", tx_data[48:1]);
    end
    drain();
  endtask

  task automatic test_reset_mid_frame();
    tx_ready = 1'b0;
    ts_now   = 48'd900;
    load_ch(2, 16'h0BAD, 32'd5, 16'd5, 1'b0, 48'd899);
    expect_accept(2);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== last_w1) begin
      errors++;
      $display("[TB] FAIL in_w1 valid=%0b data=%h, required 1 %h", tx_valid, tx_data, last_w1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_valid, tx_last, tx_data, tx_ch, frame_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset valid=%0b last=%0b data=%h ch=%0d cnt=%0d, required all 0",
               tx_valid, tx_last, tx_data, tx_ch, frame_cnt);
    end
    exp_q.delete();
    seq_model  = '0;
    frames_exp = 0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    load_ch(1, 16'h1111, 32'd1, 16'd1, 1'b1, 48'd800);
    load_ch(3, 16'h3333, 32'd3, 16'd3, 1'b0, 48'd700);
    expect_accept(1);
    in_valid[3] = 1'b0;
  endtask

  task automatic test_back_to_back();
    int prev;
    int ch;
    prev = accept_cyc;
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ch     = (2 + i) % NUM_CH;
      ts_now = 48'(1000 + 17 * i);
      load_ch(ch, 16'(16'h2000 + i), 32'(i * 1013), 16'(i + 1), i[0], 48'(1000 + 3 * i));
      expect_accept(ch);
      checks++;
      if (accept_cyc - prev !== BEATS + 1) begin
        errors++;
        $display("[TB] FAIL frame_spacing frame%0d got %0d cycles, required %0d", i, accept_cyc - prev, BEATS + 1);
      end
      prev = accept_cyc;
    end
    drain();
    checks++;
    if (seq_model !== 4'd1 || frames_exp != 17) begin
      errors++;
      $display("[TB] FAIL seq_wrap_model seq=%0d frames=%0d, required 1 and 17", seq_model, frames_exp);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    frames_exp = 0;
    seq_model  = '0;
    accept_cyc = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_round_robin();
    test_latency_wrap();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
